// File: rtl/uart_rx_if.sv
// Serial receive interface. The line side drives rx, and the receiver returns
// the received byte together with its status pulses.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  // Line side: drives the serial input and observes the receiver outputs.
  modport master (
    output rx,
    input  rx_data, rx_valid, frame_err, busy
  );

  // Receiver side.
  modport slave (
    input  rx,
    output rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The sampling point is mid-bit: the start bit is
// confirmed HALF cycles after the falling edge, and each later bit is
// sampled one full bit period after the previous sample.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 10316
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic        rx_meta, rx_s;
  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shift, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // Two-flop synchronizer. Both flops reset to the idle level so that no
  // false start edge appears after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples the values from before the clock edge.
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. The counter is cleared at every sample point, so it
  // never exceeds CLKS_PER_BIT-1 and cannot wrap.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d   = state;
    cnt_d     = cnt + 16'd1;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx with CLKS_PER_BIT = 16. The line is driven on the
// falling clock edge and outputs are observed on the falling edge. A monitor
// records every output pulse, and each test compares the recorded pulses
// with the list of pulses it expects from the frames it sent.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  obs[$];
  logic [7:0] last_data = 8'h00;
  logic prev_valid = 1'b0;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records pulses and checks rules that hold at every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.rx_valid || u_if.frame_err) begin
        ev_t ev;
        ev.is_err = u_if.frame_err;
        ev.data   = u_if.rx_data;
        ev.t      = cyc;
        obs.push_back(ev);
      end
      n_cmp++;
      if (u_if.rx_valid && u_if.frame_err) begin
        n_bad++;
        $display("FAIL both_pulses at cycle %0d: rx_valid=1 frame_err=1, expected at most one high", cyc);
      end
      if (u_if.rx_valid) begin
        n_cmp++;
        if (prev_valid) begin
          n_bad++;
          $display("FAIL valid_width at cycle %0d: rx_valid high two cycles running, expected one", cyc);
        end
        last_data = u_if.rx_data;
      end else begin
        n_cmp++;
        if (u_if.rx_data !== last_data) begin
          n_bad++;
          $display("FAIL data_stable at cycle %0d: rx_data=%02h, expected %02h", cyc, u_if.rx_data, last_data);
        end
      end
    end else begin
      last_data = 8'h00;
    end
    prev_valid = u_if.rx_valid;
  end

  task automatic idle(input int n);
    u_if.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    u_if.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    u_if.rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset();
    u_if.rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (u_if.rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %02h want 00", u_if.rx_data); end
    n_cmp++;
    if (u_if.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", u_if.rx_valid); end
    n_cmp++;
    if (u_if.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", u_if.frame_err); end
    n_cmp++;
    if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", u_if.busy); end
    rst_n = 1'b1;
    idle(CPB);
  endtask

  task automatic test_single();
    int p;
    obs.delete();
    p = cyc;
    send_frame(8'hA5, 1'b1);
    idle(4);
    n_cmp++;
    if (obs.size() != 1) begin
      n_bad++; $display("FAIL single_count: got %0d pulses want 1", obs.size());
    end else begin
      n_cmp++;
      if (obs[0].is_err || obs[0].data !== 8'hA5) begin
        n_bad++; $display("FAIL single_data: got err=%0d data=%02h want err=0 data=a5", obs[0].is_err, obs[0].data);
      end
      // Start seen two synchronizer cycles after the line edge; the pulse
      // follows the stop sample at HALF + 9 bit periods.
      n_cmp++;
      if (obs[0].t != p + 3 + HALF + 9 * CPB) begin
        n_bad++; $display("FAIL single_latency: got cycle %0d want %0d", obs[0].t, p + 3 + HALF + 9 * CPB);
      end
    end
    n_cmp++;
    if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", u_if.busy); end
  endtask

  task automatic test_back_to_back();
    obs.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    n_cmp++;
    if (obs.size() != 2) begin
      n_bad++; $display("FAIL b2b_count: got %0d pulses want 2", obs.size());
    end else begin
      n_cmp++;
      if (obs[0].is_err || obs[0].data !== 8'h00 || obs[1].is_err || obs[1].data !== 8'hFF) begin
        n_bad++;
        $display("FAIL b2b_data: got %0d/%02h %0d/%02h want 0/00 0/ff",
                 obs[0].is_err, obs[0].data, obs[1].is_err, obs[1].data);
      end
      n_cmp++;
      if (obs[1].t - obs[0].t != 10 * CPB) begin
        n_bad++; $display("FAIL b2b_spacing: got %0d cycles want %0d", obs[1].t - obs[0].t, 10 * CPB);
      end
    end
  endtask

  task automatic test_false_start();
    int p;
    obs.delete();
    p = cyc;
    u_if.rx = 1'b0;
    repeat (3) @(negedge clk);
    u_if.rx = 1'b1;
    wait_cyc(p + 2 + HALF);
    n_cmp++;
    if (u_if.busy !== 1'b1) begin n_bad++; $display("FAIL false_busy_sample: got %b want 1", u_if.busy); end
    wait_cyc(p + 3 + HALF);
    n_cmp++;
    if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL false_busy_after: got %b want 0", u_if.busy); end
    idle(2 * CPB);
    n_cmp++;
    if (obs.size() != 0) begin n_bad++; $display("FAIL false_pulses: got %0d pulses want 0", obs.size()); end
  endtask

  task automatic test_frame_err();
    obs.delete();
    send_frame(8'h81, 1'b1);
    idle(4);
    send_frame(8'h3C, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    n_cmp++;
    if (u_if.busy !== 1'b1) begin n_bad++; $display("FAIL ferr_busy_break: got %b want 1", u_if.busy); end
    idle(5);
    n_cmp++;
    if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy_release: got %b want 0", u_if.busy); end
    n_cmp++;
    if (obs.size() != 2) begin
      n_bad++; $display("FAIL ferr_count: got %0d pulses want 2", obs.size());
    end else begin
      n_cmp++;
      if (obs[0].is_err || obs[0].data !== 8'h81 || !obs[1].is_err) begin
        n_bad++;
        $display("FAIL ferr_events: got %0d/%02h %0d want 0/81 1", obs[0].is_err, obs[0].data, obs[1].is_err);
      end
    end
    n_cmp++;
    if (u_if.rx_data !== 8'h81) begin n_bad++; $display("FAIL ferr_hold: got %02h want 81", u_if.rx_data); end
  endtask

  task automatic test_break();
    obs.delete();
    u_if.rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    idle(2 * CPB);
    send_frame(8'h5A, 1'b1);
    idle(4);
    n_cmp++;
    if (obs.size() != 2) begin
      n_bad++; $display("FAIL break_count: got %0d pulses want 2", obs.size());
    end else begin
      n_cmp++;
      if (!obs[0].is_err || obs[1].is_err || obs[1].data !== 8'h5A) begin
        n_bad++;
        $display("FAIL break_events: got %0d %0d/%02h want 1 0/5a", obs[0].is_err, obs[1].is_err, obs[1].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs.delete();
    u_if.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      u_if.rx = (8'hC3 >> i) & 8'h01;
      repeat (CPB) @(negedge clk);
    end
    u_if.rx = 1'b0;
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (u_if.rx_data !== 8'h00 || u_if.busy !== 1'b0 || u_if.rx_valid !== 1'b0 || u_if.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got data=%02h busy=%b valid=%b err=%b want 00 0 0 0",
               u_if.rx_data, u_if.busy, u_if.rx_valid, u_if.frame_err);
    end
    rst_n = 1'b1;
    idle(2 * CPB);
    n_cmp++;
    if (obs.size() != 0) begin n_bad++; $display("FAIL midrst_pulses: got %0d pulses want 0", obs.size()); end
    send_frame(8'hC3, 1'b1);
    idle(4);
    n_cmp++;
    if (obs.size() != 1 || obs[0].is_err || obs[0].data !== 8'hC3) begin
      n_bad++; $display("FAIL midrst_next: got %0d pulses, first data=%02h want 1 pulse c3",
                        obs.size(), (obs.size() > 0) ? obs[0].data : 8'hxx);
    end
  endtask

  task automatic test_random();
    ev_t exp_q[$];
    logic [7:0] last_good;
    last_good = u_if.rx_data;
    obs.delete();
    for (int f = 0; f < 12; f++) begin
      ev_t e;
      logic [7:0] b;
      logic good;
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good);
      e.is_err = !good;
      e.data   = good ? b : last_good;
      e.t      = 0;
      exp_q.push_back(e);
      if (good) last_good = b;
      if (good) idle($urandom_range(0, 12));
      else      idle($urandom_range(2, 12));
    end
    idle(2 * CPB);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rand_count: got %0d pulses want %0d", obs.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (obs[i].is_err != exp_q[i].is_err || (!exp_q[i].is_err && obs[i].data !== exp_q[i].data)) begin
          n_bad++;
          $display("FAIL rand_frame%0d: got err=%0d data=%02h want err=%0d data=%02h",
                   i, obs[i].is_err, obs[i].data, exp_q[i].is_err, exp_q[i].data);
        end
      end
    end
    n_cmp++;
    if (u_if.rx_data !== last_good) begin
      n_bad++; $display("FAIL rand_last_data: got %02h want %02h", u_if.rx_data, last_good);
    end
  endtask

  initial begin
    u_if.rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_break();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
